eth_link_mgr: RTL and testbench

- Per-channel 10G SFP+ link supervisor, parametrised in channel count.
- Sits between the GT wizard / eth_phy_10g instances and the core.
- Debounces rx_block_lock and rx_high_ber into a link-up state.
- Recovers a channel that never locks by pulsing a per-channel GT RX datapath reset.
- Counts retries and link drops, and drives two status LEDs per channel.

---
 rtl/eth_link_mgr_pkg.sv | 25 ++
 rtl/eth_link_mgr_ch.sv | 136 +++++++++++++
 rtl/eth_link_mgr.sv | 64 ++++++
 tb/tb_eth_link_mgr.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_link_mgr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_link_mgr_pkg
// Brief    : Shared state encoding and helpers for the 10G link supervisor.
// Revision : 1.0 - initial release
// ============================================================================
package eth_link_mgr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RECOVER = 2'd2,
    ST_UP      = 2'd3
  } link_state_e;

  // Increment that sticks at the all-ones value of a `width`-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] w_max;
    w_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= w_max) ? value : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_link_mgr_ch.sv
`default_nettype none
// ============================================================================
// Module   : eth_link_mgr_ch
// Brief    : One SFP+ channel: input sync, link FSM, recovery timer, counters.
// Revision : 1.0 - initial release
// ============================================================================
module eth_link_mgr_ch
  import eth_link_mgr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT    = 1048576,
  parameter int RESET_PULSE     = 16,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_gt_reset_done,
  input  logic                 i_rx_block_lock,
  input  logic                 i_rx_high_ber,
  input  logic                 i_clear_counters,
  input  logic                 i_blink,
  output logic                 o_link_up,
  output logic                 o_rx_reset_req,
  output logic [CNT_WIDTH-1:0] o_retry_count,
  output logic [CNT_WIDTH-1:0] o_drop_count,
  output logic                 o_led_up,
  output logic                 o_led_search
);

  localparam int c_tmr_w = (LOCK_TIMEOUT > 1)    ? $clog2(LOCK_TIMEOUT)    : 1;
  localparam int c_deb_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_pls_w = $clog2(RESET_PULSE + 1);

  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_pls_w-1:0] c_pls_last = c_pls_w'(RESET_PULSE - 1);

  logic                 r_lock_meta, r_lock_sync;
  logic                 r_ber_meta, r_ber_sync;
  logic                 w_good;
  link_state_e          r_state, w_state_nxt;
  logic [c_tmr_w-1:0]   r_timer;
  logic [c_deb_w-1:0]   r_deb;
  logic [c_pls_w-1:0]   r_pulse;
  logic [CNT_WIDTH-1:0] r_retry, r_drop;
  logic                 w_enter_recover;
  logic                 w_link_lost;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_ber_meta  <= 1'b0;
      r_ber_sync  <= 1'b0;
    end else begin
      r_lock_meta <= i_rx_block_lock;
      r_lock_sync <= r_lock_meta;
      r_ber_meta  <= i_rx_high_ber;
      r_ber_sync  <= r_ber_meta;
    end
  end

  assign w_good = r_lock_sync & ~r_ber_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Debounce success takes priority over the lock timeout in WAIT.
  always_comb begin
    w_state_nxt     = r_state;
    w_enter_recover = 1'b0;
    w_link_lost     = 1'b0;
    if (!i_gt_reset_done) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (w_good && (r_deb == c_deb_last)) begin
            w_state_nxt = ST_UP;
          end else if (r_timer == c_tmr_last) begin
            w_state_nxt     = ST_RECOVER;
            w_enter_recover = 1'b1;
          end
        end
        ST_RECOVER: begin
          if (r_pulse == c_pls_last) w_state_nxt = ST_WAIT;
        end
        ST_UP: begin
          if (!w_good) begin
            w_state_nxt = ST_WAIT;
            w_link_lost = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Holding the timers at zero outside WAIT/RECOVER gives a clean start on entry.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state != ST_WAIT)) begin
      r_timer <= '0;
      r_deb   <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
      r_deb   <= w_good ? r_deb + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (r_state != ST_RECOVER)) r_pulse <= '0;
    else                                   r_pulse <= r_pulse + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear_counters) begin
      r_retry <= '0;
      r_drop  <= '0;
    end else begin
      if (w_enter_recover) r_retry <= CNT_WIDTH'(sat_inc(32'(r_retry), CNT_WIDTH));
      if (w_link_lost)     r_drop  <= CNT_WIDTH'(sat_inc(32'(r_drop), CNT_WIDTH));
    end
  end

  assign o_link_up      = (r_state == ST_UP);
  assign o_rx_reset_req = (r_state == ST_RECOVER);
  assign o_retry_count  = r_retry;
  assign o_drop_count   = r_drop;
  assign o_led_up       = o_link_up;
  assign o_led_search   = i_blink & ((r_state == ST_WAIT) | (r_state == ST_RECOVER));

endmodule
`default_nettype wire

// File: rtl/eth_link_mgr.sv
`default_nettype none
// ============================================================================
// Module   : eth_link_mgr
// Brief    : Multi-channel 10G SFP+ link supervisor with shared LED blink.
// Revision : 1.0 - initial release
// ============================================================================
module eth_link_mgr
  import eth_link_mgr_pkg::*;
#(
  parameter int CH_COUNT        = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT    = 1048576,
  parameter int RESET_PULSE     = 16,
  parameter int CNT_WIDTH       = 8,
  parameter int BLINK_LOG       = 23
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gt_reset_done,
  input  logic [CH_COUNT-1:0]           rx_block_lock,
  input  logic [CH_COUNT-1:0]           rx_high_ber,
  input  logic                          clear_counters,
  output logic [CH_COUNT-1:0]           link_up,
  output logic [CH_COUNT-1:0]           rx_reset_req,
  output logic [CH_COUNT*CNT_WIDTH-1:0] retry_count,
  output logic [CH_COUNT*CNT_WIDTH-1:0] drop_count,
  output logic [CH_COUNT*2-1:0]         led
);

  logic [BLINK_LOG:0] r_blink_div;

  always_ff @(posedge clk) begin
    if (!rst_n) r_blink_div <= '0;
    else        r_blink_div <= r_blink_div + 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < CH_COUNT; g++) begin : g_ch
      eth_link_mgr_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LOCK_TIMEOUT    (LOCK_TIMEOUT),
        .RESET_PULSE     (RESET_PULSE),
        .CNT_WIDTH       (CNT_WIDTH)
      ) u_ch (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_gt_reset_done  (gt_reset_done),
        .i_rx_block_lock  (rx_block_lock[g]),
        .i_rx_high_ber    (rx_high_ber[g]),
        .i_clear_counters (clear_counters),
        .i_blink          (r_blink_div[BLINK_LOG]),
        .o_link_up        (link_up[g]),
        .o_rx_reset_req   (rx_reset_req[g]),
        .o_retry_count    (retry_count[g*CNT_WIDTH +: CNT_WIDTH]),
        .o_drop_count     (drop_count[g*CNT_WIDTH +: CNT_WIDTH]),
        .o_led_up         (led[2*g]),
        .o_led_search     (led[2*g+1])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_eth_link_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_link_mgr
// Brief    : Self-checking bench for eth_link_mgr against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_link_mgr;

  localparam int CH = 2, D = 4, T = 32, P = 3, W = 4, BL = 3;
  localparam int OFF = 0, SEARCH = 1, RESETTING = 2, LINKED = 3;
  localparam int CMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gt_reset_done = 1'b0;
  logic          clear_counters = 1'b0;
  logic [CH-1:0] rx_block_lock = '0;
  logic [CH-1:0] rx_high_ber = '0;
  logic [CH-1:0] link_up, rx_reset_req;
  logic [CH*W-1:0] retry_count, drop_count;
  logic [CH*2-1:0] led;
  logic [23:0]   dut_vec;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural view of each channel
  int m_mode[CH], m_wt[CH], m_run[CH], m_left[CH], m_retry[CH], m_drop[CH];
  bit m_l1[CH], m_l2[CH], m_b1[CH], m_b2[CH];
  int m_div;

  eth_link_mgr #(
    .CH_COUNT(CH), .DEBOUNCE_CYCLES(D), .LOCK_TIMEOUT(T),
    .RESET_PULSE(P), .CNT_WIDTH(W), .BLINK_LOG(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gt_reset_done(gt_reset_done),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .clear_counters(clear_counters), .link_up(link_up),
    .rx_reset_req(rx_reset_req), .retry_count(retry_count),
    .drop_count(drop_count), .led(led)
  );

  always #5 clk = ~clk;

  assign dut_vec = {link_up, rx_reset_req, retry_count, drop_count, led};

  function automatic logic [23:0] exp_vec();
    logic [1:0] lu, rr;
    logic [7:0] rc, dc;
    logic [3:0] ld;
    lu = '0; rr = '0; rc = '0; dc = '0; ld = '0;
    for (int ch = 0; ch < CH; ch++) begin
      lu[ch] = (m_mode[ch] == LINKED);
      rr[ch] = (m_mode[ch] == RESETTING);
      rc[ch*W +: W] = W'(m_retry[ch]);
      dc[ch*W +: W] = W'(m_drop[ch]);
      ld[2*ch]   = lu[ch];
      ld[2*ch+1] = ((m_mode[ch] == SEARCH) || (m_mode[ch] == RESETTING)) && (((m_div >> BL) & 1) == 1);
    end
    return {lu, rr, rc, dc, ld};
  endfunction

  task automatic model_step();
    bit good;
    int run_now;
    if (!rst_n) begin
      m_div = 0;
      for (int ch = 0; ch < CH; ch++) begin
        m_mode[ch] = OFF; m_wt[ch] = 0; m_run[ch] = 0; m_left[ch] = 0;
        m_retry[ch] = 0; m_drop[ch] = 0;
        m_l1[ch] = 0; m_l2[ch] = 0; m_b1[ch] = 0; m_b2[ch] = 0;
      end
      return;
    end
    m_div++;
    for (int ch = 0; ch < CH; ch++) begin
      good = m_l2[ch] & ~m_b2[ch];
      if (!gt_reset_done) begin
        m_mode[ch] = OFF;
      end else if (m_mode[ch] == OFF) begin
        m_mode[ch] = SEARCH; m_wt[ch] = 0; m_run[ch] = 0;
      end else if (m_mode[ch] == SEARCH) begin
        run_now = good ? m_run[ch] + 1 : 0;
        if (good && run_now == D) begin
          m_mode[ch] = LINKED;
        end else if (m_wt[ch] + 1 == T) begin
          m_mode[ch] = RESETTING; m_left[ch] = P;
          if (m_retry[ch] < CMAX) m_retry[ch]++;
        end else begin
          m_wt[ch]++; m_run[ch] = run_now;
        end
      end else if (m_mode[ch] == RESETTING) begin
        m_left[ch]--;
        if (m_left[ch] == 0) begin
          m_mode[ch] = SEARCH; m_wt[ch] = 0; m_run[ch] = 0;
        end
      end else begin
        if (!good) begin
          m_mode[ch] = SEARCH; m_wt[ch] = 0; m_run[ch] = 0;
          if (m_drop[ch] < CMAX) m_drop[ch]++;
        end
      end
      if (clear_counters) begin
        m_retry[ch] = 0; m_drop[ch] = 0;
      end
      m_l2[ch] = m_l1[ch]; m_l1[ch] = rx_block_lock[ch];
      m_b2[ch] = m_b1[ch]; m_b1[ch] = rx_high_ber[ch];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gt_reset_done = 1'b1; rx_block_lock = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (dut_vec !== 24'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 24'h0);
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_link_up();
    rst_n = 1'b1; gt_reset_done = 1'b1; rx_block_lock = 2'b01; rx_high_ber = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL link_up cyc %0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
    end
    n_tests++;
    if (link_up !== 2'b01 || rx_reset_req !== 2'b00) begin
      n_fail++; $display("FAIL link_up_final: got link %b req %b expected 01 00", link_up, rx_reset_req);
    end
  endtask

  task automatic test_recover();
    for (int i = 0; i < (CMAX + 1) * (T + P) + T + 8; i++) begin
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL recover cyc %0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
    end
    n_tests++;
    if (retry_count[2*W-1:W] !== 4'hF) begin
      n_fail++; $display("FAIL retry_saturate: got %h expected f", retry_count[2*W-1:W]);
    end
  endtask

  task automatic test_ber_drop();
    rx_high_ber[0] = 1'b1;
    tick();
    rx_high_ber[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL ber_drop cyc %0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
      tick();
    end
    n_tests++;
    if (drop_count[W-1:0] !== 4'd1 || link_up[0] !== 1'b1) begin
      n_fail++; $display("FAIL ber_drop_final: got drop %0d link %b expected 1 1", drop_count[W-1:0], link_up[0]);
    end
  endtask

  task automatic test_debounce_restart();
    logic [7:0] pat;
    pat = 8'b1111_0111;
    rx_block_lock[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 18; i++) begin
      rx_block_lock[0] = (i < 8) ? pat[i] : 1'b1;
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL debounce cyc %0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_gt_reset_mid_recover();
    bit found, prev;
    found = 0; prev = rx_reset_req[1];
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL mid_recover_wait cyc %0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
      if (rx_reset_req[1] && !prev) found = 1;
      prev = rx_reset_req[1];
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL mid_recover_timeout: got no pulse expected pulse within 100 cycles");
    end
    tick();
    gt_reset_done = 1'b0;
    tick();
    n_tests++;
    if (rx_reset_req !== 2'b00 || link_up !== 2'b00 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL mid_recover_drop: got %h expected %h", dut_vec, exp_vec());
    end
    gt_reset_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL mid_recover_resume cyc %0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_clear_collision();
    bit found;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_mode[1] == SEARCH && m_wt[1] == T - 1) found = 1;
      else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL clear_wait_timeout: got no timeout edge expected one within 100 cycles");
    end
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    n_tests++;
    if (retry_count[2*W-1:W] !== 4'd0 || rx_reset_req[1] !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL clear_collision: got %h expected %h", dut_vec, exp_vec());
    end
    n_tests++;
    if (link_up[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_up: got %b expected 1", link_up[0]);
    end
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (dut_vec !== 24'h0) begin
      n_fail++; $display("FAIL reset_mid_up: got %h expected %h", dut_vec, 24'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (rx_block_lock[ch] ? ($urandom_range(39) == 0) : ($urandom_range(3) == 0))
          rx_block_lock[ch] = ~rx_block_lock[ch];
        rx_high_ber[ch] = ($urandom_range(63) == 0);
      end
      if ($urandom_range(299) == 0)                    gt_reset_done = 1'b0;
      else if (!gt_reset_done && $urandom_range(3) == 0) gt_reset_done = 1'b1;
      clear_counters = ($urandom_range(99) == 0);
      rst_n = ($urandom_range(999) != 0);
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_link_up();
    test_recover();
    test_ber_drop();
    test_debounce_restart();
    test_gt_reset_mid_recover();
    test_clear_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
